de1_soc_io_core: RTL and testbench

- Board-level top for the DE1-SoC that needs no processor.
- Reads the 10 slide switches and two push-buttons, and keeps a 16-bit accumulator.
- Shows the accumulator on HEX3..HEX0 and LEDR.
- Generates a 640x480@60 Hz VGA colour-bar raster from the 50 MHz board clock.

---
 rtl/de1_soc_io_core.sv | 230 +++++++++++++++++++++++
 tb/tb_de1_soc_io_core.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/de1_soc_io_core.sv
// de1_soc_io_core: processor-less DE1-SoC top. Switches and push-buttons
// drive a 16-bit accumulator shown on HEX3..HEX0/LEDR; VGA shows colour bars.
//
// Ports:
//   CLOCK_50     50 MHz clock, all registers on its rising edge
//   KEY[2]       asynchronous active-low reset
//   KEY[1]       active-low button: load acc with SW
//   KEY[0]       active-low button: add SW to acc (mod 2^16)
//   SW[9:0]      unsigned operand
//   LEDR[9:0]    acc[9:0]
//   HEX0..HEX3   active-low {g,f,e,d,c,b,a} of acc nibbles 0..3
//   VGA_R/G/B    8-bit colour channels
//   VGA_HS/VS    active-low syncs, 640x480@60
//   VGA_CLK      25 MHz pixel clock
//   VGA_BLANK_N  high in the visible region
//
// Build option: define DE1_SOC_DEBOUNCE_EN to add per-button debounce
// counters (DEBOUNCE_CYCLES consecutive reads to accept/re-arm).
module de1_soc_io_core #(
    parameter int DEBOUNCE_CYCLES = 32
) (
    input  logic       CLOCK_50,
    input  logic [2:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_CLK,
    output logic       VGA_BLANK_N
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic       w_rst_n;
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] w_press;

    assign w_rst_n = KEY[2];

    // Synchronisers idle in the released (high) state.
    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
        end else begin
            r_sync1 <= KEY[1:0];
            r_sync2 <= r_sync1;
        end
    end

`ifdef DE1_SOC_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0][CW-1:0] r_cnt;
    logic [1:0]         r_armed;
    logic [1:0]         w_hit;

    // Armed: count low reads, fire on the last one and disarm.
    // Disarmed: count high reads, re-arm after a full run.
    always_comb begin
        w_hit   = '0;
        w_press = '0;
        for (int i = 0; i < 2; i++) begin
            w_hit[i]   = (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
            w_press[i] = r_armed[i] & ~r_sync2[i] & w_hit[i];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cnt   <= '0;
            r_armed <= 2'b11;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] != r_armed[i]) begin
                    if (w_hit[i]) begin
                        r_cnt[i]   <= '0;
                        r_armed[i] <= ~r_armed[i];
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CW'(1);
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end
`else
    logic [1:0] r_prev;

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_prev <= 2'b11;
        end else begin
            r_prev <= r_sync2;
        end
    end

    assign w_press = r_prev & ~r_sync2;
`endif

    logic [15:0] r_acc;
    logic [9:0]  r_ledr;
    logic [6:0]  r_hex0;
    logic [6:0]  r_hex1;
    logic [6:0]  r_hex2;
    logic [6:0]  r_hex3;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Load has priority over add when both pulse together.
    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_acc  <= '0;
            r_ledr <= '0;
            r_hex0 <= 7'h40;
            r_hex1 <= 7'h40;
            r_hex2 <= 7'h40;
            r_hex3 <= 7'h40;
        end else begin
            if (w_press[1]) begin
                r_acc <= {6'b0, SW};
            end else if (w_press[0]) begin
                r_acc <= r_acc + {6'b0, SW};
            end
            r_ledr <= r_acc[9:0];
            r_hex0 <= seg7(r_acc[3:0]);
            r_hex1 <= seg7(r_acc[7:4]);
            r_hex2 <= seg7(r_acc[11:8]);
            r_hex3 <= seg7(r_acc[15:12]);
        end
    end

    assign LEDR = r_ledr;
    assign HEX0 = r_hex0;
    assign HEX1 = r_hex1;
    assign HEX2 = r_hex2;
    assign HEX3 = r_hex3;

    logic       r_pix_en;
    logic [9:0] r_h;
    logic [9:0] r_v;
    logic       r_hs;
    logic       r_vs;
    logic       r_blank_n;
    logic [7:0] r_r;
    logic [7:0] r_g;
    logic [7:0] r_b;
    logic       w_vis;
    logic [2:0] w_bar;

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pix_en <= 1'b0;
            r_h      <= '0;
            r_v      <= '0;
        end else begin
            r_pix_en <= ~r_pix_en;
            if (r_pix_en) begin
                if (r_h == 10'd799) begin
                    r_h <= '0;
                    r_v <= (r_v == 10'd524) ? 10'd0 : r_v + 10'd1;
                end else begin
                    r_h <= r_h + 10'd1;
                end
            end
        end
    end

    assign w_vis = (r_h < 10'd640) && (r_v < 10'd480);
    assign w_bar = 3'(r_h / 10'd80);

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
            r_r       <= '0;
            r_g       <= '0;
            r_b       <= '0;
        end else begin
            r_hs      <= !((r_h >= 10'd656) && (r_h <= 10'd751));
            r_vs      <= !((r_v >= 10'd490) && (r_v <= 10'd491));
            r_blank_n <= w_vis;
            r_r       <= (w_vis && w_bar[2]) ? 8'hFF : 8'h00;
            r_g       <= (w_vis && w_bar[1]) ? 8'hFF : 8'h00;
            r_b       <= (w_vis && w_bar[0]) ? 8'hFF : 8'h00;
        end
    end

    assign VGA_CLK     = r_pix_en;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VGA_BLANK_N = r_blank_n;
    assign VGA_R       = r_r;
    assign VGA_G       = r_g;
    assign VGA_B       = r_b;

endmodule

// File: tb/tb_de1_soc_io_core.sv
// tb_de1_soc_io_core: scoreboard bench for de1_soc_io_core.
// Button stimulus feeds an expected-acc queue; monitors check display and VGA.
module tb_de1_soc_io_core;

    logic       clk = 1'b0;
    logic [2:0] key = 3'b011;
    logic [9:0] sw  = 10'd1;
    logic [9:0] LEDR;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_CLK, VGA_BLANK_N;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [15:0] exp_q [$];
    logic [15:0] model_acc = 16'd0;

    always #10 clk = ~clk;

    de1_soc_io_core dut (
        .CLOCK_50(clk), .KEY(key), .SW(sw), .LEDR(LEDR),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_CLK(VGA_CLK),
        .VGA_BLANK_N(VGA_BLANK_N)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, want);
        end
    endtask

    function automatic logic [37:0] disp_of(input logic [15:0] v);
        return {SEG[v[15:12]], SEG[v[11:8]], SEG[v[7:4]], SEG[v[3:0]],
                v[9:0]};
    endfunction

    function automatic logic [37:0] disp_now();
        return {HEX3, HEX2, HEX1, HEX0, LEDR};
    endfunction

    // Display monitor: each visible change consumes one expected value.
    logic [37:0] prev_disp = '0;
    always @(negedge clk) begin
        logic [37:0] cur;
        logic [37:0] old;
        cur = disp_now();
        if (key[2] !== 1'b1) begin
            prev_disp = cur;
        end else if (cur !== prev_disp) begin
            old = prev_disp;
            prev_disp = cur;
            if (exp_q.size() == 0)
                chk("unexpected_update", 64'(cur), 64'(old));
            else
                chk("acc_display", 64'(cur), 64'(disp_of(exp_q.pop_front())));
        end
    end

    // VGA monitor: pixel index derived from cycles since reset release.
    int k = 0;
    int hs_fall = -1;
    int bl_rise = -1;
    logic hs_prev = 1'b1;
    logic bl_prev = 1'b0;
    always @(posedge clk) begin
        int p, h, v, b;
        logic ebl, ehs, evs;
        logic [7:0] er, eg, eb;
        #1;
        if (key[2] !== 1'b1) begin
            k = 0;
            hs_fall = -1;
            bl_rise = -1;
            hs_prev = 1'b1;
            bl_prev = 1'b0;
            chk("rst_vga",
                64'({VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B}),
                64'({1'b0, 1'b1, 1'b1, 1'b0, 24'h0}));
        end else begin
            k++;
            p = (k - 1) / 2;
            h = p % 800;
            v = (p / 800) % 525;
            b = h / 80;
            ebl = (h < 640) && (v < 480);
            ehs = !((h >= 656) && (h < 752));
            evs = !((v >= 490) && (v < 492));
            er = (ebl && ((b / 4) % 2 == 1)) ? 8'hFF : 8'h00;
            eg = (ebl && ((b / 2) % 2 == 1)) ? 8'hFF : 8'h00;
            eb = (ebl && (b % 2 == 1)) ? 8'hFF : 8'h00;
            chk("vga_clk", 64'(VGA_CLK), 64'(k % 2));
            chk("vga_pixel",
                64'({VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B}),
                64'({ehs, evs, ebl, er, eg, eb}));
            if (hs_prev && !VGA_HS) begin
                if (hs_fall >= 0) chk("hs_period", 64'(k - hs_fall), 64'(1600));
                hs_fall = k;
            end
            if (!hs_prev && VGA_HS && hs_fall >= 0)
                chk("hs_width", 64'(k - hs_fall), 64'(192));
            if (!bl_prev && VGA_BLANK_N) bl_rise = k;
            if (bl_prev && !VGA_BLANK_N && bl_rise >= 0)
                chk("blank_width", 64'(k - bl_rise), 64'(1280));
            hs_prev = VGA_HS;
            bl_prev = VGA_BLANK_N;
        end
    end

    task automatic check_acc(input string name, input logic [15:0] v);
        chk(name, 64'(disp_now()), 64'(disp_of(v)));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    task automatic press(input logic [1:0] btn, input int hold, input int gap);
        @(negedge clk);
        key[1:0] = ~btn;
        repeat (hold) @(negedge clk);
        key[1:0] = 2'b11;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_load(input logic [9:0] v, input int hold);
        sw = v;
        model_acc = {6'b0, v};
        exp_q.push_back(model_acc);
        press(2'b10, hold, 60);
        drain();
    endtask

    task automatic do_add(input logic [9:0] v, input int hold);
        sw = v;
        model_acc = model_acc + {6'b0, v};
        exp_q.push_back(model_acc);
        press(2'b01, hold, 60);
        drain();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] r;
        repeat (5) @(negedge clk);
        check_acc("reset_display", 16'h0000);
        key[2] = 1'b1;
        repeat (20) @(negedge clk);
        check_acc("idle_display", 16'h0000);

        // First load with latency probe: acc on edge 3, display on edge 4.
        sw = 10'd5;
        model_acc = 16'h0005;
        exp_q.push_back(model_acc);
        @(negedge clk);
        key[1] = 1'b0;
`ifndef DE1_SOC_DEBOUNCE_EN
        repeat (3) @(posedge clk);
        #1 chk("latency_early", 64'(LEDR), 64'(0));
        @(posedge clk);
        #1 chk("latency_edge4", 64'(LEDR), 64'(5));
`endif
        repeat (50) @(negedge clk);
        key[1] = 1'b1;
        repeat (60) @(negedge clk);
        drain();
        check_acc("load_5", 16'h0005);

        do_add(10'd3, 50);
        check_acc("add_3", 16'h0008);

        do_load(10'h3FF, 50);
        for (int i = 0; i < 63; i++) do_add(10'h3FF, 50);
        check_acc("acc_ffc0", 16'hFFC0);
        do_add(10'h3FF, 50);
        check_acc("acc_wrap", 16'h03BF);

        // Both buttons in the same cycle: load wins.
        sw = 10'h00C;
        model_acc = 16'h000C;
        exp_q.push_back(model_acc);
        press(2'b11, 50, 60);
        drain();
        check_acc("both_load_wins", 16'h000C);

        // 10 us hold gives exactly one update.
        do_add(10'd7, 500);
        check_acc("long_hold", 16'h0013);

`ifdef DE1_SOC_DEBOUNCE_EN
        sw = 10'd1;
        press(2'b01, 20, 60);
        check_acc("glitch_ignored", model_acc);
`endif

        for (int i = 0; i < 20; i++) begin
            r = 10'($urandom_range(1, 1023));
            if ($urandom_range(0, 1) == 1) begin
                if ({6'b0, r} == model_acc) r = r ^ 10'd1;
                do_load(r, int'($urandom_range(50, 90)));
            end else begin
                do_add(r, int'($urandom_range(50, 90)));
            end
        end
        check_acc("random_end", model_acc);

        // Reset mid-frame, then the raster and accumulator restart.
        repeat (333) @(negedge clk);
        key[2] = 1'b0;
        model_acc = 16'h0000;
        exp_q.delete();
        repeat (10) @(negedge clk);
        check_acc("midframe_reset", 16'h0000);
        key[2] = 1'b1;
        repeat (1700) @(negedge clk);
        do_add(10'd9, 50);
        check_acc("after_reset_add", 16'h0009);
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
